// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the register-file write-back path.
// Pure declarations; no timing or flow control of its own.
package wb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_ADDR_W-1:0] rd);
        return NUM_REGS'(1) << rd;
    endfunction

    function automatic logic is_writable(input logic [REG_ADDR_W-1:0] rd);
        return rd != ZERO_REG;
    endfunction
endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of ALU, load request/response, decode-query and register-file write signals.
// master = pipeline side, slave = write-back arbiter; forwarding taps exist only with WB_BYPASS_EN.
interface writeback_arbiter_if import wb_pkg::*; #(parameter int width = 32);
    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [width-1:0]      alu_data;
    logic                  alu_ready;
    logic                  mem_req_valid;
    logic [REG_ADDR_W-1:0] mem_req_rd;
    logic                  mem_req_ready;
    logic                  mem_resp_valid;
    logic [width-1:0]      mem_resp_data;
    logic [REG_ADDR_W-1:0] Rs_addr;
    logic [REG_ADDR_W-1:0] Rt_addr;
    logic                  busy_rs;
    logic                  busy_rt;
    logic                  we;
    logic [REG_ADDR_W-1:0] Rd_addr;
    logic [width-1:0]      Rd_data;
`ifdef WB_BYPASS_EN
    logic                  fwd_rs;
    logic                  fwd_rt;
    logic [width-1:0]      fwd_data;
`endif

    modport master (
        output alu_valid, alu_rd, alu_data, mem_req_valid, mem_req_rd,
               mem_resp_valid, mem_resp_data, Rs_addr, Rt_addr,
        input  alu_ready, mem_req_ready, busy_rs, busy_rt, we, Rd_addr, Rd_data
`ifdef WB_BYPASS_EN
        , input fwd_rs, fwd_rt, fwd_data
`endif
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_req_valid, mem_req_rd,
               mem_resp_valid, mem_resp_data, Rs_addr, Rt_addr,
        output alu_ready, mem_req_ready, busy_rs, busy_rt, we, Rd_addr, Rd_data
`ifdef WB_BYPASS_EN
        , output fwd_rs, fwd_rt, fwd_data
`endif
    );
endinterface

// File: rtl/writeback_arbiter_load_tag_fifo.sv
// In-order queue of outstanding load destination tags; pop data is combinational from the head.
// Caller qualifies push/pop; a push while full is legal only together with a pop.
module load_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the indices meet.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU results and in-order load returns into one registered write port (1 cycle, loads first).
// ALU stalls only while its one-entry skid is occupied; load issue stalls when the tag queue is full. Option: WB_BYPASS_EN.
module writeback_arbiter import wb_pkg::*; #(
    parameter int width    = 32,
    parameter int LQ_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    writeback_arbiter_if.slave wb
);
    logic                  lq_full;
    logic                  lq_empty;
    logic                  lq_push;
    logic                  lq_pop;
    logic [REG_ADDR_W-1:0] lq_tag;

    logic [NUM_REGS-1:0]   pend;
    logic [NUM_REGS-1:0]   set_mask;
    logic [NUM_REGS-1:0]   clr_mask;

    wb_entry_t             alu_entry;
    wb_entry_t             load_entry;
    wb_entry_t             sel;
    wb_entry_t             skid_q;
    wb_entry_t             skid_d;
    logic                  skid_full_q;
    logic                  skid_full_d;
    logic                  sel_vld;
    logic                  alu_acc;

    logic                  we_q;
    logic [REG_ADDR_W-1:0] rd_addr_q;
    logic [width-1:0]      rd_data_q;

    // A request that arrives while full is still taken when the head pops in the same cycle.
    assign lq_pop            = wb.mem_resp_valid & ~lq_empty;
    assign lq_push           = wb.mem_req_valid & (~lq_full | lq_pop);
    assign wb.mem_req_ready  = ~lq_full;

    load_tag_fifo #(
        .DEPTH (LQ_DEPTH),
        .W     (REG_ADDR_W)
    ) u_lq (
        .clk      (clk),
        .rst      (rst),
        .push     (lq_push),
        .push_dat (wb.mem_req_rd),
        .pop      (lq_pop),
        .pop_dat  (lq_tag),
        .full     (lq_full),
        .empty    (lq_empty)
    );

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (lq_push && is_writable(wb.mem_req_rd)) set_mask = reg_bit(wb.mem_req_rd);
        if (lq_pop)                                clr_mask = reg_bit(lq_tag);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend <= '0;
        else     pend <= (pend & ~clr_mask) | set_mask;
    end

    assign wb.alu_ready = ~skid_full_q;
    assign alu_acc      = wb.alu_valid & ~skid_full_q;

    always_comb begin
        alu_entry.rd    = wb.alu_rd;
        alu_entry.data  = DATA_W'(wb.alu_data);
        load_entry.rd   = lq_tag;
        load_entry.data = DATA_W'(wb.mem_resp_data);
    end

    always_comb begin
        sel_vld     = 1'b0;
        sel         = '0;
        skid_full_d = skid_full_q;
        skid_d      = skid_q;
        if (lq_pop) begin
            sel_vld = 1'b1;
            sel     = load_entry;
            // Skid is known empty here because alu_acc requires it.
            if (alu_acc) begin
                skid_full_d = 1'b1;
                skid_d      = alu_entry;
            end
        end else if (skid_full_q) begin
            sel_vld     = 1'b1;
            sel         = skid_q;
            skid_full_d = 1'b0;
        end else if (alu_acc) begin
            sel_vld = 1'b1;
            sel     = alu_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_full_q <= 1'b0;
            skid_q      <= '0;
        end else begin
            skid_full_q <= skid_full_d;
            skid_q      <= skid_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q      <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else if (sel_vld && is_writable(sel.rd)) begin
            we_q      <= 1'b1;
            rd_addr_q <= sel.rd;
            rd_data_q <= width'(sel.data);
        end else begin
            we_q      <= 1'b0;
        end
    end

    assign wb.we      = we_q;
    assign wb.Rd_addr = rd_addr_q;
    assign wb.Rd_data = rd_data_q;

`ifdef WB_BYPASS_EN
    // Data for a matching popped tag is already on its way, so decode need not wait for the pend bit.
    assign wb.busy_rs  = pend[wb.Rs_addr] & ~(lq_pop & (lq_tag == wb.Rs_addr));
    assign wb.busy_rt  = pend[wb.Rt_addr] & ~(lq_pop & (lq_tag == wb.Rt_addr));
    assign wb.fwd_rs   = we_q & (rd_addr_q == wb.Rs_addr);
    assign wb.fwd_rt   = we_q & (rd_addr_q == wb.Rt_addr);
    assign wb.fwd_data = rd_data_q;
`else
    assign wb.busy_rs  = pend[wb.Rs_addr];
    assign wb.busy_rt  = pend[wb.Rt_addr];
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed and random stimulus for writeback_arbiter, checked against a queue-based reference model.
module tb_writeback_arbiter;
    localparam int LQD = 4;

    typedef struct {
        int          rd;
        logic [31:0] data;
    } ent_t;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    int          m_lq[$];
    ent_t        m_skid[$];
    bit   [31:0] m_pend;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;

    writeback_arbiter_if #(.width(32)) wb();

    writeback_arbiter #(.width(32), .LQ_DEPTH(LQD)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lq.delete();
        m_skid.delete();
        m_pend   = '0;
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
    endtask

    task automatic drive(input bit av, input int ard, input logic [31:0] ad,
                         input bit rv, input int rrd, input bit pv, input logic [31:0] pd,
                         input int rs, input int rt);
        wb.alu_valid      = av;
        wb.alu_rd         = 5'(ard);
        wb.alu_data       = ad;
        wb.mem_req_valid  = rv;
        wb.mem_req_rd     = 5'(rrd);
        wb.mem_resp_valid = pv;
        wb.mem_resp_data  = pd;
        wb.Rs_addr        = 5'(rs);
        wb.Rt_addr        = 5'(rt);
    endtask

    task automatic idle(input int rs, input int rt);
        drive(0, 0, 0, 0, 0, 0, 0, rs, rt);
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model, check registered outputs after the edge.
    task automatic tick();
        bit   pop, push, acc, have, b_rs, b_rt;
        int   tag, rs, rt;
        ent_t cand, a;
        @(negedge clk);
        rs   = int'(wb.Rs_addr);
        rt   = int'(wb.Rt_addr);
        pop  = wb.mem_resp_valid && (m_lq.size() > 0);
        tag  = pop ? m_lq[0] : -1;
        b_rs = m_pend[rs];
        b_rt = m_pend[rt];
`ifdef WB_BYPASS_EN
        if (pop && tag == rs) b_rs = 1'b0;
        if (pop && tag == rt) b_rt = 1'b0;
        chk("fwd_rs", wb.fwd_rs, exp_we && (exp_addr == 5'(rs)));
        chk("fwd_rt", wb.fwd_rt, exp_we && (exp_addr == 5'(rt)));
        chk("fwd_data", wb.fwd_data, exp_data);
`endif
        chk("alu_ready", wb.alu_ready, m_skid.size() == 0);
        chk("mem_req_ready", wb.mem_req_ready, m_lq.size() < LQD);
        chk("busy_rs", wb.busy_rs, b_rs);
        chk("busy_rt", wb.busy_rt, b_rt);

        push   = wb.mem_req_valid && (m_lq.size() < LQD || pop);
        acc    = wb.alu_valid && (m_skid.size() == 0);
        a.rd   = int'(wb.alu_rd);
        a.data = wb.alu_data;
        have   = 1'b0;
        cand   = a;
        if (pop) begin
            cand.rd   = m_lq.pop_front();
            cand.data = wb.mem_resp_data;
            have      = 1'b1;
            if (acc) m_skid.push_back(a);
        end else if (m_skid.size() > 0) begin
            cand = m_skid.pop_front();
            have = 1'b1;
        end else if (acc) begin
            have = 1'b1;
        end
        if (pop) m_pend[tag] = 1'b0;
        if (push) begin
            if (wb.mem_req_rd != 0) m_pend[wb.mem_req_rd] = 1'b1;
            m_lq.push_back(int'(wb.mem_req_rd));
        end
        if (have && cand.rd != 0) begin
            exp_we   = 1'b1;
            exp_addr = 5'(cand.rd);
            exp_data = cand.data;
        end else begin
            exp_we   = 1'b0;
        end

        @(posedge clk);
        #1;
        chk("we", wb.we, exp_we);
        chk("Rd_addr", wb.Rd_addr, exp_addr);
        chk("Rd_data", wb.Rd_data, exp_data);
    endtask

    initial begin
        rst = 1'b1;
        idle(0, 0);
        model_reset();
        #12;
        chk("rst_we", wb.we, 1'b0);
        chk("rst_Rd_addr", wb.Rd_addr, 5'd0);
        chk("rst_Rd_data", wb.Rd_data, 32'd0);
        chk("rst_alu_ready", wb.alu_ready, 1'b1);
        chk("rst_mem_req_ready", wb.mem_req_ready, 1'b1);
        chk("rst_busy_rs", wb.busy_rs, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ALU-only writes, including a discarded r0 write.
        idle(0, 0);                              tick();
        drive(1, 5, 32'h1234, 0, 0, 0, 0, 5, 0); tick();
        chk("alu_we", wb.we, 1'b1);
        chk("alu_addr", wb.Rd_addr, 5'd5);
        chk("alu_data", wb.Rd_data, 32'h1234);
        drive(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0); tick();
        chk("alu_r0_we", wb.we, 1'b0);

        // Load/ALU collision: load wins, ALU result parks in the skid.
        drive(0, 0, 0, 1, 7, 0, 0, 7, 3);                  tick();
        idle(7, 3);                                        tick();
        drive(1, 3, 32'hBBBB, 0, 0, 1, 32'hAAAA, 7, 3);    tick();
        chk("coll_addr", wb.Rd_addr, 5'd7);
        chk("coll_data", wb.Rd_data, 32'hAAAA);
        idle(7, 3);                                        tick();
        chk("coll_alu_addr", wb.Rd_addr, 5'd3);
        chk("coll_alu_data", wb.Rd_data, 32'hBBBB);

        // Fill the load queue, then push and pop together while full.
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, 1, i, 0, 0, i, 1); tick();
        end
        chk("full_ready", wb.mem_req_ready, 1'b0);
        drive(0, 0, 0, 1, 12, 1, 32'h100, 1, 12); tick();
        chk("full_pushpop_ready", wb.mem_req_ready, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            drive(0, 0, 0, 0, 0, 1, 32'h100 + 32'(i), i, 12); tick();
        end

        // Set wins over clear for the same register.
        drive(0, 0, 0, 1, 9, 0, 0, 9, 9);           tick();
        drive(0, 0, 0, 1, 9, 1, 32'h9A, 9, 9);      tick();
        chk("setwins_busy", wb.busy_rs, 1'b1);
        drive(0, 0, 0, 0, 0, 1, 32'h9B, 9, 9);      tick();
        idle(9, 9);                                 tick();
        chk("setwins_clear", wb.busy_rs, 1'b0);

        // Reset with loads pending and the skid full.
        drive(0, 0, 0, 1, 10, 0, 0, 11, 10);              tick();
        drive(0, 0, 0, 1, 11, 0, 0, 11, 10);              tick();
        drive(0, 0, 0, 1, 12, 0, 0, 11, 10);              tick();
        drive(1, 6, 32'h6666, 0, 0, 1, 32'hA0, 11, 12);   tick();
        chk("pre_rst_skid_full", wb.alu_ready, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_we", wb.we, 1'b0);
        chk("mid_rst_Rd_addr", wb.Rd_addr, 5'd0);
        chk("mid_rst_Rd_data", wb.Rd_data, 32'd0);
        chk("mid_rst_alu_ready", wb.alu_ready, 1'b1);
        chk("mid_rst_mem_req_ready", wb.mem_req_ready, 1'b1);
        chk("mid_rst_busy_rs", wb.busy_rs, 1'b0);
        chk("mid_rst_busy_rt", wb.busy_rt, 1'b0);
        #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 1, 32'hF00D, 11, 12); tick();
        chk("post_rst_resp_we", wb.we, 1'b0);
        idle(0, 0);                                tick();

        // Random traffic over a small register range to provoke collisions and hazards.
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 9) < 4, $urandom_range(0, 7),
                  $urandom_range(0, 9) < 4, $urandom,
                  $urandom_range(0, 7), $urandom_range(0, 7));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Owns the write port of the 32×32 register file. Merges single-cycle ALU results and variable-latency, in-order load returns into one registered write stream (`we`/`Rd_addr`/`Rd_data`). Keeps a pending-load scoreboard that tells decode when `Rs`/`Rt` is waiting on a load. Sits between EX/MEM and the register file; the register file commits on the negedge after this block's posedge update.

## Interface
- `width`, 32, data width of a register.
- `LQ_DEPTH`, 4, maximum number of outstanding loads (power of two, ≥2).
- `clk` in 1: sole clock, all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `alu_valid` in 1: ALU result present.
- `alu_rd` in 5: destination of the ALU result.
- `alu_data` in width: ALU result.
- `alu_ready` out 1: ALU result accepted this cycle when high with `alu_valid`.
- `mem_req_valid` in 1: load issued to memory.
- `mem_req_rd` in 5: load destination.
- `mem_req_ready` out 1: load queue can accept a tag.
- `mem_resp_valid` in 1: load data returned, in issue order.
- `mem_resp_data` in width: returned load data.
- `Rs_addr`, `Rt_addr` in 5: decode source operands.
- `busy_rs`, `busy_rt` out 1: operand has a pending load.
- `we` out 1: register-file write enable.
- `Rd_addr` out 5: register-file write address.
- `Rd_data` out width: register-file write data.

## Operation
- Load queue: a FIFO of `LQ_DEPTH` 5-bit tags.
  - Push on `mem_req_valid & mem_req_ready`; `mem_req_ready = !full`.
  - Pop on `mem_resp_valid & !empty`. A response while the queue is empty is ignored.
  - Push and pop in the same cycle are both honoured, including when full.
- Scoreboard: 32 pending bits.
  - Set `pend[mem_req_rd]` on push; clear `pend[tag]` on pop.
  - Same register set and cleared in one cycle: set wins.
  - `pend[0]` is never set.
  - `busy_rs = pend[Rs_addr]` and `busy_rt = pend[Rt_addr]`, combinational.
- Arbitration, each cycle (load has priority):
  - A popped load always goes to the output stage.
  - ALU result path: if the skid buffer is full, its entry goes to the output when no load pops. Otherwise an accepted ALU result goes to the output when no load pops, else into the skid buffer.
  - `alu_ready = !skid_full`.
  - The ALU waits indefinitely under back-to-back loads (accepted).
- Output stage is registered. `we` is set only if the selected entry exists and its rd ≠ 0; `Rd_addr`/`Rd_data` hold the last value when `we = 0`.
- ALU writes to a pending rd are performed and leave the pend bit unchanged.

## Timing
- Reset values: `we = 0`, `Rd_addr = 0`, `Rd_data = 0`, `alu_ready = 1`, `mem_req_ready = 1`, `busy_* = 0`. Queue empty, skid empty, scoreboard clear.
- Reset mid-operation discards all queued tags, the skid entry and pend bits; later responses are ignored.
- ALU latency: accepted in cycle N with no load pop → `we = 1` in N+1. With a load pop in N → buffered, written in the first cycle M > N with no pop, `we = 1` at M+1.
- Load latency: response in N → `we = 1` in N+1. The pend bit drops at the posedge ending N, so `busy` is low in N+1.
- The register file commits on the negedge of the cycle where `we = 1`.

## Configuration
- `WB_BYPASS_EN` defined: adds outputs `fwd_rs`/`fwd_rt` (1 bit) and `fwd_data` (width).
  - `fwd_rs` is high when the current output stage has `we & Rd_addr == Rs_addr`; `fwd_rt` likewise for `Rt_addr`. `fwd_data = Rd_data`.
  - `busy_*` additionally drops in the response cycle N when the popped tag matches, so decode may proceed one cycle earlier.
- Undefined: those ports and logic are absent; `busy_*` is exactly the registered scoreboard.

## Structure
- Package `wb_pkg`: `REG_ADDR_W = 5`, `NUM_REGS = 32`, `ZERO_REG = 0`, typedef `wb_entry_t {rd, data}` used by the skid and output stages.
- One sub-module: `load_tag_fifo` (parameterised depth, push/pop/full/empty, same-cycle push+pop when full).

## Test plan
- ALU only: `alu_rd = 5`, data `0x1234` in cycle 2 → `we = 1`, `Rd_addr = 5`, `Rd_data = 0x1234` in cycle 3; `alu_rd = 0` → `we` stays 0.
- Collision: load tag 7 pending. In cycle 10, `mem_resp 0xAAAA` arrives with ALU `rd 3 / 0xBBBB` → cycle 11 writes r7 `= 0xAAAA` with `alu_ready = 0`; cycle 12 writes r3 `= 0xBBBB`.
- Queue full: 4 loads issued (rd 1–4) → `mem_req_ready = 0` and `busy` high for r1–r4. Responses return in order → writes r1..r4, each busy drops the cycle after its response.
- Full + simultaneous push/pop: a 5th request coincides with a response → both are accepted, count stays 4.
- Set-wins: load r9 responding in the same cycle a new load r9 is requested → `pend[9]` stays 1 until the second response.
- Reset: assert `rst` with 2 loads pending and the skid full → all outputs at reset values immediately; a subsequent `mem_resp_valid` produces no write.
